// File: rtl/aurora_os_tx.sv
// aurora_os_tx: serialises 1-4 byte ordered sets, data bytes and pseudo-random idles into one K-flagged byte stream.
// Latency: 1 cycle from the accept edge to tx_data_o; later bytes of a set follow on each tx_ce_i strobe.
// Backpressure: readies are low unless tx_ce_i is high at a byte boundary; define AURORA_OS_CC_EN for CC bursts.
module aurora_os_tx #(
    parameter logic [6:0] LFSR_SEED = 7'h7F,
    parameter int         CC_PERIOD = 5000,
    parameter int         CC_REPEAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_ce_i,
    input  logic [31:0] os_i,
    input  logic        os_valid_i,
    output logic        os_ready_o,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_is_k_o,
    output logic        busy_o
);

    // Ordered-set codes with special handling; real sets carry their bytes LSB first.
    localparam logic [31:0] OS_NONE = 32'h0000_0000;
    localparam logic [31:0] OS_I    = 32'h0000_0001;

    localparam logic [7:0] K28_5 = 8'hBC;
    localparam logic [7:0] K28_3 = 8'h7C;
    localparam logic [7:0] K28_0 = 8'h1C;
`ifdef AURORA_OS_CC_EN
    localparam logic [7:0]  K23_7    = 8'hF7;
    localparam logic [12:0] CC_LAST  = 13'(CC_PERIOD - 1);
    localparam logic [7:0]  CC_BYTES = 8'(2 * CC_REPEAT - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        SEND_OS
`ifdef AURORA_OS_CC_EN
        ,
        SEND_CC
`endif
    } state_t;

    state_t      state, state_nxt;
    logic [7:0]  data_nxt;
    logic        k_nxt;
    logic [23:0] sh, sh_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic [6:0]  lfsr, lfsr_nxt;
    logic [4:0]  a_cnt, a_cnt_nxt;
    logic        first_idle, first_nxt;
    logic [1:0]  os_last;
    logic        cc_pending;
`ifdef AURORA_OS_CC_EN
    logic [12:0] cc_cnt, cc_cnt_nxt;
    logic        cc_pending_nxt;
    logic [7:0]  cc_left, cc_left_nxt;
`else
    assign cc_pending = 1'b0;
`endif

    // K28.x plus the four K x.7 codes used by Aurora; everything else is data.
    function automatic logic is_k(input logic [7:0] b);
        return (b == 8'hF7) || (b == 8'hFB) || (b == 8'hFD) || (b == 8'hFE) || (b[4:0] == 5'b11100);
    endfunction

    assign os_ready_o   = rst_n & tx_ce_i & (state == IDLE) & ~cc_pending;
    assign data_ready_o = os_ready_o & ~os_valid_i;
    assign busy_o       = (state != IDLE);

    // Index of the highest nonzero byte of the requested set (set length minus one).
    always_comb begin
        os_last = 2'd0;
        if (os_i[31:24] != 8'd0)      os_last = 2'd3;
        else if (os_i[23:16] != 8'd0) os_last = 2'd2;
        else if (os_i[15:8] != 8'd0)  os_last = 2'd1;
    end

    // Next-state and next-output selection; nothing moves without a byte strobe.
    always_comb begin
        state_nxt  = state;
        data_nxt   = tx_data_o;
        k_nxt      = tx_is_k_o;
        sh_nxt     = sh;
        cnt_nxt    = cnt;
        lfsr_nxt   = lfsr;
        a_cnt_nxt  = a_cnt;
        first_nxt  = first_idle;
`ifdef AURORA_OS_CC_EN
        cc_cnt_nxt     = cc_cnt;
        cc_pending_nxt = cc_pending;
        cc_left_nxt    = cc_left;
`endif
        if (tx_ce_i) begin
            case (state)
                IDLE: begin
                    if (cc_pending) begin
`ifdef AURORA_OS_CC_EN
                        data_nxt       = K23_7;
                        k_nxt          = 1'b1;
                        cc_left_nxt    = CC_BYTES;
                        cc_pending_nxt = 1'b0;
                        state_nxt      = SEND_CC;
`endif
                    end else if (os_valid_i && (os_i != OS_NONE) && (os_i != OS_I)) begin
                        data_nxt = os_i[7:0];
                        k_nxt    = is_k(os_i[7:0]);
                        sh_nxt   = os_i[31:8];
                        cnt_nxt  = os_last;
                        if (os_last != 2'd0) state_nxt = SEND_OS;
                    end else if (!os_valid_i && data_valid_i) begin
                        data_nxt = data_i;
                        k_nxt    = 1'b0;
                    end else begin
                        // Idle byte: forced K after reset, then A on counter expiry, else K/R by LFSR.
                        k_nxt    = 1'b1;
                        lfsr_nxt = {lfsr[5:0], lfsr[6] ^ lfsr[5]};
                        if (first_idle) begin
                            data_nxt  = K28_5;
                            first_nxt = 1'b0;
                            a_cnt_nxt = a_cnt - 5'd1;
                        end else if (a_cnt == 5'd0) begin
                            data_nxt  = K28_3;
                            a_cnt_nxt = 5'd16 + {1'b0, lfsr[3:0]};
                        end else begin
                            data_nxt  = lfsr[0] ? K28_0 : K28_5;
                            a_cnt_nxt = a_cnt - 5'd1;
                        end
                    end
                end
                SEND_OS: begin
                    data_nxt = sh[7:0];
                    k_nxt    = is_k(sh[7:0]);
                    sh_nxt   = {8'd0, sh[23:8]};
                    cnt_nxt  = cnt - 2'd1;
                    if (cnt == 2'd1) state_nxt = IDLE;
                end
`ifdef AURORA_OS_CC_EN
                SEND_CC: begin
                    data_nxt    = K23_7;
                    k_nxt       = 1'b1;
                    cc_left_nxt = cc_left - 8'd1;
                    if (cc_left == 8'd1) state_nxt = IDLE;
                end
`endif
                default: state_nxt = IDLE;
            endcase
`ifdef AURORA_OS_CC_EN
            // Expiry is evaluated last so a new period is never lost to the clear above.
            if (cc_cnt == CC_LAST) begin
                cc_cnt_nxt     = 13'd0;
                cc_pending_nxt = 1'b1;
            end else begin
                cc_cnt_nxt = cc_cnt + 13'd1;
            end
`endif
        end
    end

    // Main state and output registers; reset aborts any set in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tx_data_o  <= K28_5;
            tx_is_k_o  <= 1'b1;
            sh         <= 24'd0;
            cnt        <= 2'd0;
            lfsr       <= LFSR_SEED;
            a_cnt      <= 5'd16 + {1'b0, LFSR_SEED[3:0]};
            first_idle <= 1'b1;
        end else begin
            state      <= state_nxt;
            tx_data_o  <= data_nxt;
            tx_is_k_o  <= k_nxt;
            sh         <= sh_nxt;
            cnt        <= cnt_nxt;
            lfsr       <= lfsr_nxt;
            a_cnt      <= a_cnt_nxt;
            first_idle <= first_nxt;
        end
    end

`ifdef AURORA_OS_CC_EN
    // Clock-compensation period counter and burst bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_cnt     <= 13'd0;
            cc_pending <= 1'b0;
            cc_left    <= 8'd0;
        end else begin
            cc_cnt     <= cc_cnt_nxt;
            cc_pending <= cc_pending_nxt;
            cc_left    <= cc_left_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_aurora_os_tx.sv
// tb_aurora_os_tx: randomized and directed checks of aurora_os_tx against a byte-queue reference model.
// Latency: outputs sampled 1 time unit after each strobed rising edge; readies sampled just before it.
// Backpressure: requests are held until the model says they are accepted.
module tb_aurora_os_tx;

    localparam logic [31:0] OS_NONE = 32'h0000_0000;
    localparam logic [31:0] OS_I    = 32'h0000_0001;
    localparam logic [31:0] OS_SP   = 32'h4A4A_4ABC;
    localparam logic [31:0] OS_SPA  = 32'h2C2C_2CBC;
    localparam logic [31:0] OS_VER  = 32'hE8E8_E8BC;
    localparam logic [31:0] OS_SCP  = 32'h0000_FB5C;
    localparam logic [31:0] OS_ECP  = 32'h0000_FEFD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ce = 1'b0;
    logic [31:0] os = 32'd0;
    logic        ov = 1'b0;
    logic        os_ready;
    logic [7:0]  d = 8'd0;
    logic        dv = 1'b0;
    logic        data_ready;
    logic [7:0]  tx_data;
    logic        tx_is_k;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: idle generator plus queue of outstanding set bytes {k, byte}.
    int         m_lfsr;
    int         m_acnt;
    bit         m_first;
    logic [8:0] m_q[$];

    always #5 clk = ~clk;

`ifdef AURORA_OS_CC_EN
    aurora_os_tx #(.CC_PERIOD(20), .CC_REPEAT(3)) dut (
`else
    aurora_os_tx dut (
`endif
        .clk(clk), .rst_n(rst_n), .tx_ce_i(ce),
        .os_i(os), .os_valid_i(ov), .os_ready_o(os_ready),
        .data_i(d), .data_valid_i(dv), .data_ready_o(data_ready),
        .tx_data_o(tx_data), .tx_is_k_o(tx_is_k), .busy_o(busy)
    );

    function automatic void model_reset();
        m_lfsr  = 127;
        m_acnt  = 16 + (127 % 16);
        m_first = 1'b1;
        m_q.delete();
    endfunction

    function automatic logic [8:0] mk(input logic [7:0] b);
        logic k;
        k = (b inside {8'hF7, 8'hFB, 8'hFD, 8'hFE}) || ((int'(b) % 32) == 28);
        return {k, b};
    endfunction

    function automatic logic [8:0] model_idle();
        logic [8:0] r;
        if (m_first) begin
            r = 9'h1BC; m_first = 1'b0; m_acnt = m_acnt - 1;
        end else if (m_acnt == 0) begin
            r = 9'h17C; m_acnt = 16 + (m_lfsr % 16);
        end else begin
            r = ((m_lfsr % 2) == 1) ? 9'h11C : 9'h1BC; m_acnt = m_acnt - 1;
        end
        m_lfsr = ((m_lfsr * 2) % 128) + (((m_lfsr >> 6) ^ (m_lfsr >> 5)) & 1);
        return r;
    endfunction

    function automatic void model_step(input logic v_os, input logic [31:0] c_os, input logic v_d,
                                       input logic [7:0] c_d, output logic e_ordy, output logic e_drdy,
                                       output logic [8:0] e_byte, output logic e_busy);
        int n;
        if (m_q.size() > 0) begin
            e_ordy = 1'b0; e_drdy = 1'b0; e_byte = m_q.pop_front();
        end else begin
            e_ordy = 1'b1; e_drdy = !v_os;
            if (v_os && c_os != OS_NONE && c_os != OS_I) begin
                n = 1;
                for (int i = 1; i < 4; i++)
                    if (((c_os >> (8 * i)) & 32'hFF) != 0) n = i + 1;
                for (int i = 1; i < n; i++)
                    m_q.push_back(mk(8'((c_os >> (8 * i)) & 32'hFF)));
                e_byte = mk(c_os[7:0]);
            end else if (!v_os && v_d) begin
                e_byte = {1'b0, c_d};
            end else begin
                e_byte = model_idle();
            end
        end
        e_busy = (m_q.size() > 0);
    endfunction

    // One strobed byte: drive requests, sample readies before the edge and outputs after it.
    task automatic strobe(input logic v_os, input logic [31:0] c_os, input logic v_d, input logic [7:0] c_d,
                          output logic o_ordy, output logic o_drdy, output logic [8:0] o_byte, output logic o_busy);
        ov = v_os; os = c_os; dv = v_d; d = c_d; ce = 1'b1;
        #1;
        o_ordy = os_ready; o_drdy = data_ready;
        @(posedge clk); #1;
        o_byte = {tx_is_k, tx_data}; o_busy = busy;
        ce = 1'b0; ov = 1'b0; dv = 1'b0;
    endtask

    task automatic test_reset();
        ce = 1'b1; ov = 1'b0; dv = 1'b0; rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (tx_data !== 8'hBC) begin n_fail++; $display("FAIL reset_data: got %h expected bc", tx_data); end
        n_checks++; if (tx_is_k !== 1'b1) begin n_fail++; $display("FAIL reset_k: got %b expected 1", tx_is_k); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (os_ready !== 1'b0) begin n_fail++; $display("FAIL reset_os_ready: got %b expected 0", os_ready); end
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
        ce = 1'b0; rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic test_idle();
        logic r, dr, bs, er, edr, ebs;
        logic [8:0] ob, eb;
        int last_a;
        last_a = -1;
        for (int i = 0; i < 150; i++) begin
            strobe(1'b0, 32'd0, 1'b0, 8'd0, r, dr, ob, bs);
            model_step(1'b0, 32'd0, 1'b0, 8'd0, er, edr, eb, ebs);
            n_checks++; if (ob !== eb) begin n_fail++; $display("FAIL idle_byte[%0d]: got %h expected %h", i, ob, eb); end
            n_checks++; if (r !== er) begin n_fail++; $display("FAIL idle_os_ready[%0d]: got %b expected %b", i, r, er); end
            if (i == 0) begin
                n_checks++; if (ob !== 9'h1BC) begin n_fail++; $display("FAIL idle_first: got %h expected 1bc", ob); end
            end
            if (ob == 9'h17C) begin
                if (last_a >= 0) begin
                    n_checks++;
                    if ((i - last_a - 1) < 16 || (i - last_a - 1) > 31) begin
                        n_fail++; $display("FAIL idle_a_gap: got %0d expected 16..31", i - last_a - 1);
                    end
                end
                last_a = i;
            end else begin
                n_checks++;
                if (!(ob inside {9'h1BC, 9'h11C})) begin n_fail++; $display("FAIL idle_kr[%0d]: got %h expected 1bc or 11c", i, ob); end
            end
        end
    endtask

    task automatic test_sp_sparse();
        logic r, dr, bs, er, edr, ebs;
        logic [8:0] ob, eb;
        logic [8:0] sp_exp[4];
        sp_exp = '{9'h1BC, 9'h04A, 9'h04A, 9'h04A};
        for (int s = 0; s < 4; s++) begin
            strobe(s == 0, OS_SP, 1'b0, 8'd0, r, dr, ob, bs);
            model_step(s == 0, OS_SP, 1'b0, 8'd0, er, edr, eb, ebs);
            n_checks++; if (ob !== sp_exp[s]) begin n_fail++; $display("FAIL sp_byte[%0d]: got %h expected %h", s, ob, sp_exp[s]); end
            n_checks++; if (r !== er) begin n_fail++; $display("FAIL sp_os_ready[%0d]: got %b expected %b", s, r, er); end
            n_checks++; if (bs !== ebs) begin n_fail++; $display("FAIL sp_busy[%0d]: got %b expected %b", s, bs, ebs); end
            repeat (7) @(posedge clk);
            #1;
            n_checks++; if ({tx_is_k, tx_data} !== eb) begin n_fail++; $display("FAIL sp_hold[%0d]: got %h expected %h", s, {tx_is_k, tx_data}, eb); end
            n_checks++; if (os_ready !== 1'b0) begin n_fail++; $display("FAIL sp_ready_no_ce[%0d]: got %b expected 0", s, os_ready); end
        end
    endtask

    task automatic test_back_to_back();
        logic r, dr, bs, er, edr, ebs;
        logic [8:0] ob, eb;
        logic [31:0] req[$];
        logic [8:0] exp_b[4];
        logic v;
        logic [31:0] c;
        exp_b = '{9'h15C, 9'h1FB, 9'h1FD, 9'h1FE};
        req.push_back(OS_SCP); req.push_back(OS_ECP);
        for (int s = 0; s < 4; s++) begin
            v = (req.size() > 0);
            c = v ? req[0] : 32'd0;
            strobe(v, c, 1'b0, 8'd0, r, dr, ob, bs);
            model_step(v, c, 1'b0, 8'd0, er, edr, eb, ebs);
            if (v && er) void'(req.pop_front());
            n_checks++; if (ob !== exp_b[s]) begin n_fail++; $display("FAIL b2b_byte[%0d]: got %h expected %h", s, ob, exp_b[s]); end
            n_checks++; if (r !== er) begin n_fail++; $display("FAIL b2b_os_ready[%0d]: got %b expected %b", s, r, er); end
        end
    endtask

    task automatic test_priority();
        logic r, dr, bs, er, edr, ebs;
        logic [8:0] ob, eb;
        logic [8:0] exp_b[5];
        logic exp_dr[5];
        logic os_pend, d_pend;
        exp_b  = '{9'h1BC, 9'h04A, 9'h04A, 9'h04A, 9'h055};
        exp_dr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        os_pend = 1'b1; d_pend = 1'b1;
        for (int s = 0; s < 5; s++) begin
            strobe(os_pend, OS_SP, d_pend, 8'h55, r, dr, ob, bs);
            model_step(os_pend, OS_SP, d_pend, 8'h55, er, edr, eb, ebs);
            if (er) os_pend = 1'b0;
            if (edr) d_pend = 1'b0;
            n_checks++; if (ob !== exp_b[s]) begin n_fail++; $display("FAIL prio_byte[%0d]: got %h expected %h", s, ob, exp_b[s]); end
            n_checks++; if (dr !== exp_dr[s]) begin n_fail++; $display("FAIL prio_data_ready[%0d]: got %b expected %b", s, dr, exp_dr[s]); end
        end
    endtask

    task automatic test_random();
        logic r, dr, bs, er, edr, ebs;
        logic [8:0] ob, eb, last_eb;
        logic [31:0] tbl[7];
        logic os_pend, d_pend;
        logic [31:0] os_val;
        logic [7:0] d_val;
        tbl = '{OS_NONE, OS_I, OS_SP, OS_SPA, OS_VER, OS_SCP, OS_ECP};
        os_pend = 1'b0; d_pend = 1'b0; os_val = 32'd0; d_val = 8'd0; last_eb = 9'd0;
        for (int s = 0; s < 400; s++) begin
            if (!os_pend && $urandom_range(3) == 0) begin
                os_pend = 1'b1; os_val = tbl[$urandom_range(6)];
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1'b1; d_val = 8'($urandom);
            end
            if (s > 0 && $urandom_range(3) == 0) begin
                ce = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                n_checks++; if ({tx_is_k, tx_data} !== last_eb) begin n_fail++; $display("FAIL rnd_hold[%0d]: got %h expected %h", s, {tx_is_k, tx_data}, last_eb); end
            end
            strobe(os_pend, os_val, d_pend, d_val, r, dr, ob, bs);
            model_step(os_pend, os_val, d_pend, d_val, er, edr, eb, ebs);
            if (os_pend && er) os_pend = 1'b0;
            if (d_pend && edr) d_pend = 1'b0;
            last_eb = eb;
            n_checks++; if (ob !== eb) begin n_fail++; $display("FAIL rnd_byte[%0d]: got %h expected %h", s, ob, eb); end
            n_checks++; if (r !== er) begin n_fail++; $display("FAIL rnd_os_ready[%0d]: got %b expected %b", s, r, er); end
            n_checks++; if (dr !== edr) begin n_fail++; $display("FAIL rnd_data_ready[%0d]: got %b expected %b", s, dr, edr); end
            n_checks++; if (bs !== ebs) begin n_fail++; $display("FAIL rnd_busy[%0d]: got %b expected %b", s, bs, ebs); end
        end
    endtask

    task automatic test_reset_mid();
        logic r, dr, bs, er, edr, ebs;
        logic [8:0] ob, eb;
        strobe(1'b1, OS_VER, 1'b0, 8'd0, r, dr, ob, bs);
        model_step(1'b1, OS_VER, 1'b0, 8'd0, er, edr, eb, ebs);
        n_checks++; if (ob !== 9'h1BC) begin n_fail++; $display("FAIL ver_byte0: got %h expected 1bc", ob); end
        strobe(1'b0, 32'd0, 1'b0, 8'd0, r, dr, ob, bs);
        n_checks++; if (ob !== 9'h0E8) begin n_fail++; $display("FAIL ver_byte1: got %h expected 0e8", ob); end
        ce = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({tx_is_k, tx_data} !== 9'h1BC) begin n_fail++; $display("FAIL midrst_out: got %h expected 1bc", {tx_is_k, tx_data}); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        @(posedge clk); #1;
        rst_n = 1'b1; ce = 1'b0;
        model_reset();
        for (int i = 0; i < 40; i++) begin
            strobe(1'b0, 32'd0, 1'b0, 8'd0, r, dr, ob, bs);
            model_step(1'b0, 32'd0, 1'b0, 8'd0, er, edr, eb, ebs);
            n_checks++; if (ob !== eb) begin n_fail++; $display("FAIL midrst_idle[%0d]: got %h expected %h", i, ob, eb); end
        end
    endtask

`ifdef AURORA_OS_CC_EN
    task automatic test_cc();
        logic r, dr, bs;
        logic [8:0] ob, eb;
        for (int s = 1; s <= 50; s++) begin
            strobe(s == 18, OS_SP, 1'b0, 8'd0, r, dr, ob, bs);
            if (s == 18 || s == 22) begin
                n_checks++; if (r !== (s == 18)) begin n_fail++; $display("FAIL cc_os_ready[%0d]: got %b expected %b", s, r, s == 18); end
            end
            if (s >= 18 && s <= 21) begin
                eb = (s == 18) ? 9'h1BC : 9'h04A;
                n_checks++; if (ob !== eb) begin n_fail++; $display("FAIL cc_sp_byte[%0d]: got %h expected %h", s, ob, eb); end
            end else if ((s >= 22 && s <= 27) || (s >= 41 && s <= 46)) begin
                n_checks++; if (ob !== 9'h1F7) begin n_fail++; $display("FAIL cc_byte[%0d]: got %h expected 1f7", s, ob); end
            end else begin
                n_checks++;
                if (!(ob inside {9'h1BC, 9'h11C, 9'h17C})) begin n_fail++; $display("FAIL cc_idle[%0d]: got %h expected idle K", s, ob); end
            end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef AURORA_OS_CC_EN
        test_cc();
`else
        test_idle();
        test_sp_sparse();
        test_back_to_back();
        test_priority();
        test_random();
        test_reset_mid();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/aurora_os_tx.md
# aurora_os_tx

Ordered-set transmit sequencer for the Aurora 8b/10b lane. It serializes 1–4 byte ordered sets (`ordered_sets_e` codes from `aurora_pkg`), single data bytes and pseudo-random idles into one byte stream with a per-byte K flag. It sits directly upstream of the 8b/10b encoder (`ENCODER_DATA_IN_SIZE` bytes in) and advances only on the encoder's byte strobe.

## Interface
Parameters:
- `LFSR_SEED`, default `7'h7F`: initial value of the idle LFSR; must be nonzero.
- `CC_PERIOD`, default `5000`: number of `tx_ce_i` strobes between clock-compensation bursts. Used only with `AURORA_OS_CC_EN`.
- `CC_REPEAT`, default `3`: number of CC ordered sets per burst. Used only with `AURORA_OS_CC_EN`.

Ports:
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous active-low reset.
- `tx_ce_i`, input, 1: byte strobe from the encoder. Outputs advance only when it is 1.
- `os_i`, input, `ORDERED_SEQUENCE_SIZE` (32): ordered-set code, of type `ordered_sets_e`.
- `os_valid_i`, input, 1: an ordered-set request is present.
- `os_ready_o`, output, 1: the request is accepted this cycle.
- `data_i`, input, 8: data byte.
- `data_valid_i`, input, 1: a data byte is present.
- `data_ready_o`, output, 1: the data byte is accepted this cycle.
- `tx_data_o`, output, 8: byte to the encoder. Registered.
- `tx_is_k_o`, output, 1: `tx_data_o` is a K character. Registered.
- `busy_o`, output, 1: a multi-byte set or a CC burst is in progress.

## Operation
- **States:** `IDLE` (byte boundary), `SEND_OS`, `SEND_CC` (only with `AURORA_OS_CC_EN`).
- **Accepting an ordered set:**
  - Set length = index of the highest nonzero byte of `os_i` + 1.
  - Bytes go out least-significant first, so `SP` sends K28_5, D10_2, D10_2, D10_2 and `SCP` sends K28_2, K27_7.
  - Byte 0 is registered on the accept edge.
  - A length of 1 stays in `IDLE`. Lengths 2–4 enter `SEND_OS` and hold the remaining bytes in a shift register with a 2-bit count.
- **Special codes:**
  - `os_i == NONE`: the request is accepted and dropped, and an idle byte is sent.
  - `os_i == I`: the request is accepted and one idle byte is sent.
- **K flag:** asserted when the byte is K23_7, K27_7, K29_7, K30_7, or has low bits `11100` (K28.x). All other bytes, including D08_7, D10_2 and D12_1, are data.
- **Ready rules:**
  - `os_ready_o = rst_n & tx_ce_i & state==IDLE & !cc_pending`.
  - `data_ready_o = os_ready_o & !os_valid_i`, so an ordered set wins over data.
  - An accepted data byte gives `tx_data_o = data_i` and `tx_is_k_o = 0`.
- **Idle generation** (on a `tx_ce_i` byte in `IDLE` with no accepted request):
  - The first idle byte after reset is K28_5.
  - A 7-bit LFSR (x^7+x^6+1) steps once per idle byte.
  - A 5-bit counter `a_cnt` is loaded with `16 + lfsr[3:0]` at reset and after each A. It decrements once per idle byte.
  - When `a_cnt == 0`, send K28_3 (A).
  - Otherwise send K28_5 (K) if `lfsr[0]==0`, else K28_0 (R).
  - Data bytes and ordered sets do not advance the LFSR or `a_cnt`.
- **Mid-set behaviour:**
  - Both readies are 0 while a set is in progress.
  - `os_i` is sampled only at accept.
  - Reset mid-set aborts it immediately.

## Timing
- Registered output with latency 1: a byte accepted on edge N appears on `tx_data_o` after edge N.
- Each following byte updates on the next edge where `tx_ce_i = 1`.
- Outputs hold their value while `tx_ce_i = 0`.
- A length-L set occupies L strobes. The next request can be accepted on strobe L+1.
- Reset values:
  - `tx_data_o = 8'hBC` (K28_5), `tx_is_k_o = 1`.
  - `os_ready_o`, `data_ready_o`, `busy_o` = 0.
  - State `IDLE`, `lfsr = LFSR_SEED`, CC counter = 0.
- `busy_o = state != IDLE`, registered.

## Configuration
- With `AURORA_OS_CC_EN` defined:
  - A 13-bit counter counts `tx_ce_i` strobes. At `CC_PERIOD-1` it sets `cc_pending` and wraps to 0.
  - At the next `IDLE` byte boundary, `cc_pending` takes priority over OS, data and idle.
  - The block then sends `CC_REPEAT` × (K23_7, K23_7), all flagged K, in `SEND_CC`, and clears `cc_pending`.
  - An expiry during a burst sets pending again; it is not lost.
- Without the macro: no CC logic, no `SEND_CC`, and `cc_pending` is tied to 0.

## Test plan
- Reset, then `tx_ce_i` held at 1 with no requests: first byte is 0xBC/K. The A (0x7C) bytes then appear 16–31 bytes apart, and every other byte is 0xBC or 0x1C with K=1.
- `SP` requested with `tx_ce_i` = 1 every 8 cycles: output is BC/K, 4A/D, 4A/D, 4A/D on four consecutive strobes. `busy_o` is high for 3 strobes and `os_ready_o` is 0 meanwhile.
- `SCP` followed back-to-back by `ECP`: output is 5C/K, FB/K, FD/K, FE/K with no idle byte between them.
- `os_valid_i` and `data_valid_i` both high with `data_i = 0x55`: the OS is sent first and `data_ready_o` stays 0. The data byte 55/D follows on the next free strobe.
- `rst_n` asserted on byte 2 of `VER`: outputs return to BC/K immediately. After release the sequence restarts from idle.
- With `AURORA_OS_CC_EN`, `CC_PERIOD = 20`, `CC_REPEAT = 3`: six F7/K bytes appear after strobe 20, deferred until the end of any in-progress `SP`.
